// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, key-schedule FSM encoding and the round-constant table.
package aes_pkg;

  localparam int KEY_W   = 128;
  localparam int WORD_W  = 32;
  localparam int NUM_RND = 10;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Round constant for rounds 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: purely combinational byte substitution.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  always_comb begin
    s = 8'h00;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: serial LSB-first key load, then one round key per clock.
// KEY_VAL rises 10 edges after the last key bit and holds until the next load starts.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         KIN,
  input  logic         KIN_VAL,
  output logic [127:0] Key_0,
  output logic [127:0] Key_1,
  output logic [127:0] Key_2,
  output logic [127:0] Key_3,
  output logic [127:0] Key_4,
  output logic [127:0] Key_5,
  output logic [127:0] Key_6,
  output logic [127:0] Key_7,
  output logic [127:0] Key_8,
  output logic [127:0] Key_9,
  output logic [127:0] Key_10,
  output logic         KEY_VAL,
  output logic         BUSY
);

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   sr_q, sr_d;
  logic [KEY_W-1:0]   work_q, work_d;
  logic [KEY_W-1:0]   key_q [11];
  logic [KEY_W-1:0]   key_d [11];
  logic [6:0]         bit_cnt_q, bit_cnt_d;
  logic [3:0]         rnd_q, rnd_d;
  logic               key_val_q, key_val_d;
  logic               busy_q, busy_d;

  logic [WORD_W-1:0]  w0, w1, w2, w3;
  logic [WORD_W-1:0]  rot_w, sub_w, t_w;
  logic [WORD_W-1:0]  nw0, nw1, nw2, nw3;
  logic [KEY_W-1:0]   next_key;

  // work_q always mirrors the most recently written round key.
  assign w0    = work_q[127:96];
  assign w1    = work_q[95:64];
  assign w2    = work_q[63:32];
  assign w3    = work_q[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot_w[8*i +: 8]),
      .s (sub_w[8*i +: 8])
    );
  end

  assign t_w      = sub_w ^ {rcon(rnd_q), 24'h000000};
  assign nw0      = w0 ^ t_w;
  assign nw1      = w1 ^ nw0;
  assign nw2      = w2 ^ nw1;
  assign nw3      = w3 ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    work_d    = work_q;
    key_d     = key_q;
    bit_cnt_d = bit_cnt_q;
    rnd_d     = rnd_q;
    key_val_d = key_val_q;
    busy_d    = busy_q;

    case (state_q)
      ST_LOAD: begin
        if (KIN_VAL) begin
          sr_d[bit_cnt_q] = KIN;
          bit_cnt_d       = bit_cnt_q + 7'd1;
          if (bit_cnt_q == 7'd127) begin
            key_d[0] = sr_d;
            work_d   = sr_d;
            rnd_d    = 4'd1;
            busy_d   = 1'b1;
            state_d  = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        for (int i = 1; i < 11; i++) begin
          if (rnd_q == 4'(i)) key_d[i] = next_key;
        end
        work_d = next_key;
        rnd_d  = rnd_q + 4'd1;
        if (rnd_q == 4'(NUM_RND)) begin
          busy_d    = 1'b0;
          key_val_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        // The bit that wakes us up is already key bit 0 of the next load.
        if (KIN_VAL) begin
          sr_d[0]   = KIN;
          bit_cnt_d = 7'd1;
          key_val_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      sr_q      <= '0;
      work_q    <= '0;
      key_q     <= '{default: '0};
      bit_cnt_q <= '0;
      rnd_q     <= '0;
      key_val_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      work_q    <= work_d;
      key_q     <= key_d;
      bit_cnt_q <= bit_cnt_d;
      rnd_q     <= rnd_d;
      key_val_q <= key_val_d;
      busy_q    <= busy_d;
    end
  end

  assign Key_0   = key_q[0];
  assign Key_1   = key_q[1];
  assign Key_2   = key_q[2];
  assign Key_3   = key_q[3];
  assign Key_4   = key_q[4];
  assign Key_5   = key_q[5];
  assign Key_6   = key_q[6];
  assign Key_7   = key_q[7];
  assign Key_8   = key_q[8];
  assign Key_9   = key_q[9];
  assign Key_10  = key_q[10];
  assign KEY_VAL = key_val_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key-schedule vectors.
module tb_aes_key_expander;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KZ     = 128'h0;
  localparam logic [127:0] KZ_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KZ_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk, reset, KIN, KIN_VAL;
  logic [127:0] Key_0, Key_1, Key_2, Key_3, Key_4, Key_5;
  logic [127:0] Key_6, Key_7, Key_8, Key_9, Key_10;
  logic         KEY_VAL, BUSY;

  int n_vec = 0;
  int n_err = 0;

  aes_key_expander dut (
    .clk     (clk),
    .reset   (reset),
    .KIN     (KIN),
    .KIN_VAL (KIN_VAL),
    .Key_0   (Key_0),
    .Key_1   (Key_1),
    .Key_2   (Key_2),
    .Key_3   (Key_3),
    .Key_4   (Key_4),
    .Key_5   (Key_5),
    .Key_6   (Key_6),
    .Key_7   (Key_7),
    .Key_8   (Key_8),
    .Key_9   (Key_9),
    .Key_10  (Key_10),
    .KEY_VAL (KEY_VAL),
    .BUSY    (BUSY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams key bits lo..hi back to back, leaving KIN_VAL low afterwards.
  task automatic send_bits(input logic [127:0] k, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      KIN     = k[i];
      KIN_VAL = 1'b1;
      tick();
    end
    KIN_VAL = 1'b0;
    KIN     = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    KIN     = 1'b0;
    KIN_VAL = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    n_vec++; if (Key_0 !== 128'h0) begin n_err++; $display("FAIL reset_key0: got %h want 0", Key_0); end
    n_vec++; if (Key_10 !== 128'h0) begin n_err++; $display("FAIL reset_key10: got %h want 0", Key_10); end
    n_vec++; if (KEY_VAL !== 1'b0) begin n_err++; $display("FAIL reset_keyval: got %b want 0", KEY_VAL); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_fips_schedule();
    int early;
    send_bits(K1, 0, 126);
    n_vec++; if (Key_0 !== 128'h0) begin n_err++; $display("FAIL fips_key0_hold: got %h want 0", Key_0); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL fips_busy_load: got %b want 0", BUSY); end
    send_bits(K1, 127, 127);
    n_vec++; if (Key_0 !== K1) begin n_err++; $display("FAIL fips_key0: got %h want %h", Key_0, K1); end
    n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL fips_busy_n: got %b want 1", BUSY); end
    n_vec++; if (KEY_VAL !== 1'b0) begin n_err++; $display("FAIL fips_keyval_n: got %b want 0", KEY_VAL); end
    early = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (KEY_VAL !== 1'b0 || BUSY !== 1'b1) early++;
    end
    n_vec++; if (early != 0) begin n_err++; $display("FAIL fips_expand_flags: got %0d bad cycles want 0", early); end
    tick();
    n_vec++; if (KEY_VAL !== 1'b1) begin n_err++; $display("FAIL fips_keyval_n10: got %b want 1", KEY_VAL); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL fips_busy_n10: got %b want 0", BUSY); end
    n_vec++; if (Key_1 !== K1_R1) begin n_err++; $display("FAIL fips_key1: got %h want %h", Key_1, K1_R1); end
    n_vec++; if (Key_5 !== K1_R5) begin n_err++; $display("FAIL fips_key5: got %h want %h", Key_5, K1_R5); end
    n_vec++; if (Key_10 !== K1_R10) begin n_err++; $display("FAIL fips_key10: got %h want %h", Key_10, K1_R10); end
  endtask

  task automatic test_expand_noise();
    send_bits(K1, 0, 127);
    for (int i = 0; i < 10; i++) begin
      KIN     = ($urandom_range(1, 0) == 1);
      KIN_VAL = ($urandom_range(1, 0) == 1);
      tick();
    end
    KIN_VAL = 1'b0;
    tick();
    tick();
    n_vec++; if (KEY_VAL !== 1'b1) begin n_err++; $display("FAIL noise_keyval: got %b want 1", KEY_VAL); end
    n_vec++; if (Key_0 !== K1) begin n_err++; $display("FAIL noise_key0: got %h want %h", Key_0, K1); end
    n_vec++; if (Key_1 !== K1_R1) begin n_err++; $display("FAIL noise_key1: got %h want %h", Key_1, K1_R1); end
    n_vec++; if (Key_5 !== K1_R5) begin n_err++; $display("FAIL noise_key5: got %h want %h", Key_5, K1_R5); end
    n_vec++; if (Key_10 !== K1_R10) begin n_err++; $display("FAIL noise_key10: got %h want %h", Key_10, K1_R10); end
  endtask

  task automatic test_reload_from_done();
    send_bits(KZ, 0, 0);
    n_vec++; if (KEY_VAL !== 1'b0) begin n_err++; $display("FAIL reload_keyval_drop: got %b want 0", KEY_VAL); end
    n_vec++; if (Key_1 !== K1_R1) begin n_err++; $display("FAIL reload_key1_stale: got %h want %h", Key_1, K1_R1); end
    send_bits(KZ, 1, 127);
    n_vec++; if (Key_0 !== KZ) begin n_err++; $display("FAIL reload_key0: got %h want %h", Key_0, KZ); end
    n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL reload_busy: got %b want 1", BUSY); end
    tick();
    n_vec++; if (Key_1 !== KZ_R1) begin n_err++; $display("FAIL reload_key1_new: got %h want %h", Key_1, KZ_R1); end
    n_vec++; if (Key_10 !== K1_R10) begin n_err++; $display("FAIL reload_key10_stale: got %h want %h", Key_10, K1_R10); end
    repeat (9) tick();
    n_vec++; if (KEY_VAL !== 1'b1) begin n_err++; $display("FAIL reload_keyval: got %b want 1", KEY_VAL); end
    n_vec++; if (Key_10 !== KZ_R10) begin n_err++; $display("FAIL reload_key10: got %h want %h", Key_10, KZ_R10); end
  endtask

  task automatic test_gaps();
    logic [127:0] k;
    int busy_early;
    int gap;
    int cnt;
    k = K1;
    busy_early = 0;
    for (int i = 0; i < 128; i++) begin
      gap = int'($urandom_range(5, 0));
      repeat (gap) begin
        KIN_VAL = 1'b0;
        KIN     = ($urandom_range(1, 0) == 1);
        tick();
        if (BUSY !== 1'b0) busy_early++;
      end
      KIN     = k[i];
      KIN_VAL = 1'b1;
      tick();
      if (i < 127 && BUSY !== 1'b0) busy_early++;
    end
    KIN_VAL = 1'b0;
    n_vec++; if (busy_early != 0) begin n_err++; $display("FAIL gaps_busy_early: got %0d cycles want 0", busy_early); end
    n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL gaps_busy_n: got %b want 1", BUSY); end
    cnt = 0;
    while (KEY_VAL !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    n_vec++; if (cnt != 10) begin n_err++; $display("FAIL gaps_latency: got %0d edges want 10", cnt); end
    n_vec++; if (Key_1 !== K1_R1) begin n_err++; $display("FAIL gaps_key1: got %h want %h", Key_1, K1_R1); end
    n_vec++; if (Key_5 !== K1_R5) begin n_err++; $display("FAIL gaps_key5: got %h want %h", Key_5, K1_R5); end
    n_vec++; if (Key_10 !== K1_R10) begin n_err++; $display("FAIL gaps_key10: got %h want %h", Key_10, K1_R10); end
  endtask

  task automatic test_reset_mid_expand();
    int cnt;
    send_bits(K1, 0, 127);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (Key_0 !== 128'h0) begin n_err++; $display("FAIL midrst_key0: got %h want 0", Key_0); end
    n_vec++; if (Key_1 !== 128'h0) begin n_err++; $display("FAIL midrst_key1: got %h want 0", Key_1); end
    n_vec++; if (Key_3 !== 128'h0) begin n_err++; $display("FAIL midrst_key3: got %h want 0", Key_3); end
    n_vec++; if (KEY_VAL !== 1'b0) begin n_err++; $display("FAIL midrst_keyval: got %b want 0", KEY_VAL); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", BUSY); end
    tick();
    n_vec++; if (Key_4 !== 128'h0) begin n_err++; $display("FAIL midrst_key4_after: got %h want 0", Key_4); end
    send_bits(K1, 0, 127);
    cnt = 0;
    while (KEY_VAL !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    n_vec++; if (cnt != 10) begin n_err++; $display("FAIL midrst_latency: got %0d edges want 10", cnt); end
    n_vec++; if (Key_1 !== K1_R1) begin n_err++; $display("FAIL midrst_key1_reload: got %h want %h", Key_1, K1_R1); end
    n_vec++; if (Key_5 !== K1_R5) begin n_err++; $display("FAIL midrst_key5_reload: got %h want %h", Key_5, K1_R5); end
    n_vec++; if (Key_10 !== K1_R10) begin n_err++; $display("FAIL midrst_key10_reload: got %h want %h", Key_10, K1_R10); end
  endtask

  initial begin
    reset   = 1'b1;
    KIN     = 1'b0;
    KIN_VAL = 1'b0;
    test_reset();
    test_fips_schedule();
    test_expand_noise();
    test_reload_from_done();
    test_gaps();
    test_reset_mid_expand();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
